// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - frame geometry defaults, coordinate type and distributor states
package pixel_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int FRAME_W    = 640;
  localparam int FRAME_H    = 480;

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} dist_state_t;

  typedef logic [DATA_WIDTH-1:0] coord_t;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational pick of the first eligible engine at or above rr_ptr, wrapping
module rr_arbiter #(
  parameter int NUM_ENGINES   = 4,
  parameter int ENG_IDX_WIDTH = 2
) (
  input  logic [NUM_ENGINES-1:0]   eligible,
  input  logic [ENG_IDX_WIDTH-1:0] rr_ptr,
  output logic [NUM_ENGINES-1:0]   grant,
  output logic [ENG_IDX_WIDTH-1:0] grant_idx,
  output logic                     grant_valid
);
  logic [NUM_ENGINES-1:0] rotated;
  int                     sel;

  // rotated[k] is engine (rr_ptr + k) mod NUM_ENGINES
  always_comb begin
    rotated     = NUM_ENGINES'({eligible, eligible} >> rr_ptr);
    grant_valid = 1'b0;
    sel         = 0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      if (!grant_valid && rotated[k]) begin
        grant_valid = 1'b1;
        sel         = (int'(rr_ptr) + k) % NUM_ENGINES;
      end
    end
    for (int i = 0; i < NUM_ENGINES; i++) begin
      grant[i] = grant_valid && (i == sel);
    end
    grant_idx = ENG_IDX_WIDTH'(sel);
  end
endmodule

// File: rtl/pixel_distributor.sv
// rtl/pixel_distributor.sv - raster-order pixel dispatcher over NUM_ENGINES engines
// PIXEL_DISTRIBUTOR_PERF_EN adds the stall_cycles_o counter.
module pixel_distributor #(
  parameter int NUM_ENGINES   = 4,
  parameter int ENG_IDX_WIDTH = 2,
  parameter int DATA_WIDTH    = pixel_pkg::DATA_WIDTH,
  parameter int FRAME_W       = pixel_pkg::FRAME_W,
  parameter int FRAME_H       = pixel_pkg::FRAME_H
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_start,
  input  logic [NUM_ENGINES-1:0]   engine_idle,
  input  logic [NUM_ENGINES-1:0]   queue_full,
  output logic [NUM_ENGINES-1:0]   start_o,
  output logic [DATA_WIDTH-1:0]    xpixel_o,
  output logic [DATA_WIDTH-1:0]    ypixel_o,
  output logic [ENG_IDX_WIDTH-1:0] grant_idx_o,
  output logic                     busy_o,
  output logic                     frame_done_o
`ifdef PIXEL_DISTRIBUTOR_PERF_EN
  ,
  output logic [31:0]              stall_cycles_o
`endif
);
  import pixel_pkg::*;

  dist_state_t              state, state_nxt;
  logic [DATA_WIDTH-1:0]    x_cnt, y_cnt;
  logic [ENG_IDX_WIDTH-1:0] rr_ptr, gnt_idx;
  logic [NUM_ENGINES-1:0]   blk_d, block, eligible, gnt;
  logic                     gnt_valid, do_grant, last_x, last_pixel;

  // start_o is last cycle's grant and blk_d the one before; together they form the block mask
  assign block      = start_o | blk_d;
  assign eligible   = engine_idle & ~queue_full & ~block;
  assign do_grant   = (state == DISPATCH) && gnt_valid;
  assign last_x     = (x_cnt == DATA_WIDTH'(FRAME_W - 1));
  assign last_pixel = last_x && (y_cnt == DATA_WIDTH'(FRAME_H - 1));

  rr_arbiter #(
    .NUM_ENGINES  (NUM_ENGINES),
    .ENG_IDX_WIDTH(ENG_IDX_WIDTH)
  ) u_arb (
    .eligible   (eligible),
    .rr_ptr     (rr_ptr),
    .grant      (gnt),
    .grant_idx  (gnt_idx),
    .grant_valid(gnt_valid)
  );

  always_comb begin
    state_nxt    = state;
    busy_o       = (state != IDLE);
    frame_done_o = (state == DONE);
    case (state)
      IDLE:     if (frame_start) state_nxt = DISPATCH;
      DISPATCH: if (do_grant && last_pixel) state_nxt = DRAIN;
      DRAIN:    if (&engine_idle && !(|block)) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      x_cnt       <= '0;
      y_cnt       <= '0;
      rr_ptr      <= '0;
      start_o     <= '0;
      blk_d       <= '0;
      xpixel_o    <= '0;
      ypixel_o    <= '0;
      grant_idx_o <= '0;
    end else begin
      state   <= state_nxt;
      start_o <= do_grant ? gnt : '0;
      blk_d   <= start_o;
      if (state == IDLE && frame_start) begin
        x_cnt  <= '0;
        y_cnt  <= '0;
        rr_ptr <= '0;
      end else if (do_grant) begin
        xpixel_o    <= x_cnt;
        ypixel_o    <= y_cnt;
        grant_idx_o <= gnt_idx;
        rr_ptr      <= (gnt_idx == ENG_IDX_WIDTH'(NUM_ENGINES - 1)) ? '0
                                                                    : gnt_idx + ENG_IDX_WIDTH'(1);
        if (last_x) begin
          x_cnt <= '0;
          y_cnt <= y_cnt + DATA_WIDTH'(1);
        end else begin
          x_cnt <= x_cnt + DATA_WIDTH'(1);
        end
      end
    end
  end

`ifdef PIXEL_DISTRIBUTOR_PERF_EN
  always_ff @(posedge clk) begin
    if (reset || (state == IDLE && frame_start)) begin
      stall_cycles_o <= '0;
    end else if (state == DISPATCH && !gnt_valid && stall_cycles_o != '1) begin
      stall_cycles_o <= stall_cycles_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pixel_distributor.sv
// tb/tb_pixel_distributor.sv - vector table, frame-level reference model and single-engine spacing
module tb_pixel_distributor;
  localparam int NE = 4;
  localparam int W  = 4;
  localparam int H  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, frame_start;
  logic [NE-1:0] engine_idle, queue_full, start_o;
  logic [31:0]   xpixel_o, ypixel_o;
  logic [1:0]    grant_idx_o;
  logic          busy_o, frame_done_o;

  logic          reset1, frame_start1, busy1, done1;
  logic [0:0]    start1, gidx1;
  logic [31:0]   x1, y1;
`ifdef PIXEL_DISTRIBUTOR_PERF_EN
  logic [31:0]   stall_cycles_o, stall1;
`endif

  pixel_distributor #(
    .NUM_ENGINES(NE), .ENG_IDX_WIDTH(2), .DATA_WIDTH(32), .FRAME_W(W), .FRAME_H(H)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .engine_idle(engine_idle), .queue_full(queue_full),
    .start_o(start_o), .xpixel_o(xpixel_o), .ypixel_o(ypixel_o),
    .grant_idx_o(grant_idx_o), .busy_o(busy_o), .frame_done_o(frame_done_o)
`ifdef PIXEL_DISTRIBUTOR_PERF_EN
    , .stall_cycles_o(stall_cycles_o)
`endif
  );

  pixel_distributor #(
    .NUM_ENGINES(1), .ENG_IDX_WIDTH(1), .DATA_WIDTH(32), .FRAME_W(3), .FRAME_H(1)
  ) dut1 (
    .clk(clk), .reset(reset1), .frame_start(frame_start1),
    .engine_idle(1'b1), .queue_full(1'b0),
    .start_o(start1), .xpixel_o(x1), .ypixel_o(y1),
    .grant_idx_o(gidx1), .busy_o(busy1), .frame_done_o(done1)
`ifdef PIXEL_DISTRIBUTOR_PERF_EN
    , .stall_cycles_o(stall1)
`endif
  );

  int checks = 0;
  int failures = 0;
  int strobe_cnt = 0;
  int done_cnt = 0;

  // frame-level reference: pixels issued so far, pointer, and the step of each engine's last grant
  int m_phase = 0;
  int m_issued = 0;
  int m_ptr = 0;
  int m_stall = 0;
  int m_step = 0;
  int m_last[NE] = '{-10, -10, -10, -10};
  logic [NE-1:0] e_start = '0;
  logic [1:0]    e_idx = '0;
  logic [31:0]   e_x = '0, e_y = '0;
  logic          e_busy = 1'b0, e_done = 1'b0;

  typedef struct packed {
    logic [3:0] full;
    logic [1:0] idx;
    logic [7:0] x;
    logic [7:0] y;
  } vec_t;
  vec_t vec[16];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (step %0d)", name, act, exp, m_step);
    end
  endtask

  task automatic model_step();
    int  g;
    bit  found, blocked;
    if (reset) begin
      m_phase = 0; m_issued = 0; m_ptr = 0; m_stall = 0;
      for (int i = 0; i < NE; i++) m_last[i] = -10;
      e_start = '0; e_idx = '0; e_x = '0; e_y = '0;
    end else begin
      e_start = '0;
      case (m_phase)
        0: if (frame_start) begin
             m_phase = 1; m_issued = 0; m_ptr = 0; m_stall = 0;
           end
        1: begin
          found = 0; g = 0;
          for (int k = 0; k < NE; k++) begin
            int i;
            i = (m_ptr + k) % NE;
            if (!found && ((engine_idle >> i) & 1) != 0 && ((queue_full >> i) & 1) == 0
                && (m_step - m_last[i] > 2)) begin
              found = 1; g = i;
            end
          end
          if (found) begin
            e_start = 4'b0001 << g;
            e_idx = 2'(g);
            e_x = m_issued % W;
            e_y = m_issued / W;
            m_issued++;
            m_ptr = (g + 1) % NE;
            m_last[g] = m_step;
            if (m_issued == W * H) m_phase = 2;
          end else begin
            m_stall++;
          end
        end
        2: begin
          blocked = 0;
          for (int i = 0; i < NE; i++) if (m_step - m_last[i] <= 2) blocked = 1;
          if (engine_idle == '1 && !blocked) m_phase = 3;
        end
        default: m_phase = 0;
      endcase
    end
    e_busy = (m_phase != 0);
    e_done = (m_phase == 3);
    m_step++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("lockstep", 128'({start_o, grant_idx_o, xpixel_o, ypixel_o, busy_o, frame_done_o}),
          128'({e_start, e_idx, e_x, e_y, e_busy, e_done}));
`ifdef PIXEL_DISTRIBUTOR_PERF_EN
    check("stall_lockstep", 128'(stall_cycles_o), 128'(m_stall));
`endif
    if (|start_o) strobe_cnt++;
    if (frame_done_o) done_cnt++;
  endtask

  task automatic wait_strobe(input string name, output bit ok);
    int c;
    ok = 0; c = 0;
    while (!ok && c < 50) begin
      tick();
      c++;
      ok = |start_o;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL %s: no strobe within 50 cycles", name);
    end
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while (busy_o && c < 3000) begin
      tick();
      c++;
    end
    if (busy_o) begin
      checks++; failures++;
      $display("FAIL %s: still busy after 3000 cycles", name);
    end
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    bit ok, seen;
    int d0, s0, c, k;
    int times[$];

    vec[0]  = '{4'h0, 2'd0, 8'd0, 8'd0};  vec[1]  = '{4'h0, 2'd1, 8'd1, 8'd0};
    vec[2]  = '{4'h0, 2'd2, 8'd2, 8'd0};  vec[3]  = '{4'h0, 2'd3, 8'd3, 8'd0};
    vec[4]  = '{4'h0, 2'd0, 8'd0, 8'd1};  vec[5]  = '{4'h0, 2'd1, 8'd1, 8'd1};
    vec[6]  = '{4'h0, 2'd2, 8'd2, 8'd1};  vec[7]  = '{4'h0, 2'd3, 8'd3, 8'd1};
    vec[8]  = '{4'h2, 2'd0, 8'd0, 8'd0};  vec[9]  = '{4'h2, 2'd2, 8'd1, 8'd0};
    vec[10] = '{4'h2, 2'd3, 8'd2, 8'd0};  vec[11] = '{4'h2, 2'd0, 8'd3, 8'd0};
    vec[12] = '{4'h2, 2'd2, 8'd0, 8'd1};  vec[13] = '{4'h2, 2'd3, 8'd1, 8'd1};
    vec[14] = '{4'h2, 2'd0, 8'd2, 8'd1};  vec[15] = '{4'h2, 2'd2, 8'd3, 8'd1};

    reset = 1'b1; frame_start = 1'b0; engine_idle = '1; queue_full = '0;
    reset1 = 1'b1; frame_start1 = 1'b0;
    d0 = 0;
    tick();
    tick();
    check("reset_state", 128'({start_o, grant_idx_o, xpixel_o, ypixel_o, busy_o, frame_done_o}), 128'(0));
    reset = 1'b0; reset1 = 1'b0;
    tick();

    // basic frame and full-skip frame from the vector table
    for (int i = 0; i < 16; i++) begin
      if (i % 8 == 0) begin
        d0 = done_cnt;
        queue_full = vec[i].full;
        pulse_start();
      end
      wait_strobe("table_wait", ok);
      if (ok) check("table_strobe", 128'({start_o, grant_idx_o, xpixel_o, ypixel_o}),
                    128'({4'b0001 << vec[i].idx, vec[i].idx, 24'd0, vec[i].x, 24'd0, vec[i].y}));
      if (i % 8 == 7) begin
        wait_idle("table_idle");
        check("table_done_once", 128'(done_cnt - d0), 128'(1));
      end
    end
    queue_full = '0;

    // total stall mid-frame
    d0 = done_cnt;
    pulse_start();
    for (int i = 0; i < 3; i++) wait_strobe("stall_pre", ok);
    queue_full = '1;
    s0 = strobe_cnt;
    repeat (10) tick();
    check("stall_no_strobe", 128'(strobe_cnt - s0), 128'(0));
    queue_full = '0;
    wait_strobe("stall_resume", ok);
    if (ok) check("stall_resume_pixel", 128'({grant_idx_o, xpixel_o, ypixel_o}), 128'({2'd3, 32'd3, 32'd0}));
    wait_idle("stall_idle");
    check("stall_done_once", 128'(done_cnt - d0), 128'(1));
`ifdef PIXEL_DISTRIBUTOR_PERF_EN
    check("stall_cycles", 128'(stall_cycles_o), 128'(10));
`endif

    // frame_start ignored in DISPATCH and DRAIN
    d0 = done_cnt; s0 = strobe_cnt;
    pulse_start();
    wait_strobe("ign_a", ok);
    wait_strobe("ign_b", ok);
    pulse_start();
    c = 0;
    while (strobe_cnt - s0 < 8 && c < 50) begin
      tick();
      c++;
    end
    pulse_start();
    wait_idle("ign_idle");
    repeat (5) tick();
    check("ign_pixels", 128'(strobe_cnt - s0), 128'(8));
    check("ign_done_once", 128'(done_cnt - d0), 128'(1));
    check("ign_idle_after", 128'(busy_o), 128'(0));

    // reset mid-frame, then restart
    pulse_start();
    for (int i = 0; i < 3; i++) wait_strobe("rst_pre", ok);
    d0 = done_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_start_zero", 128'(start_o), 128'(0));
    check("rst_busy_zero", 128'(busy_o), 128'(0));
    pulse_start();
    wait_strobe("rst_restart", ok);
    if (ok) check("rst_restart_first", 128'({start_o, grant_idx_o, xpixel_o, ypixel_o}),
                  128'({4'b0001, 2'd0, 32'd0, 32'd0}));
    wait_idle("rst_idle");
    check("rst_done_once", 128'(done_cnt - d0), 128'(1));

    // randomized frames against the reference model
    for (int f = 0; f < 6; f++) begin
      d0 = done_cnt; s0 = strobe_cnt;
      pulse_start();
      c = 0;
      while (busy_o && c < 3000) begin
        for (int b = 0; b < NE; b++) begin
          engine_idle[b] = ($urandom_range(3) != 0);
          queue_full[b]  = ($urandom_range(4) == 0);
        end
        frame_start = ($urandom_range(15) == 0);
        tick();
        c++;
      end
      frame_start = 1'b0; engine_idle = '1; queue_full = '0;
      check("rand_finished", 128'(busy_o), 128'(0));
      check("rand_pixels", 128'(strobe_cnt - s0), 128'(W * H));
      check("rand_done_once", 128'(done_cnt - d0), 128'(1));
      tick();
    end

    // single engine: strobes exactly 3 cycles apart
    frame_start1 = 1'b1;
    tick();
    frame_start1 = 1'b0;
    c = 0; k = 0; seen = 0;
    while (!seen && c < 100) begin
      tick();
      c++;
      if (start1[0]) begin
        check("single_strobe", 128'({gidx1, x1, y1}), 128'({1'b0, 32'(k), 32'd0}));
        times.push_back(c);
        k++;
      end
      if (done1) seen = 1;
    end
    check("single_count", 128'(times.size()), 128'(3));
    check("single_done", 128'(seen), 128'(1));
    for (int i = 1; i < times.size(); i++) check("single_gap", 128'(times[i] - times[i-1]), 128'(3));
`ifdef PIXEL_DISTRIBUTOR_PERF_EN
    check("single_stalls", 128'(stall1), 128'(4));
`endif
    tick();
    check("single_idle", 128'(busy1), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pixel_distributor.md
Name: pixel_distributor

Overview:
- Frame-level scheduler. Walks pixel coordinates in raster order and hands each coordinate to one of NUM_ENGINES pixel engines.
- Arbitrates round-robin among engines that are idle and whose downstream reorder queue is not full.
- Sits between the frame control logic and the engine array. The reorder queues and combinator downstream rebuild raster order.
- Raises frame_done_o once every issued pixel has finished in its engine.

Parameters:
- NUM_ENGINES, 4, number of pixel engines (2..16).
- ENG_IDX_WIDTH, 2, width of an engine index; equals clog2(NUM_ENGINES).
- DATA_WIDTH, 32, width of the coordinate buses.
- FRAME_W, 640, pixels per line.
- FRAME_H, 480, lines per frame.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  single-cycle request to begin a frame.
- engine_idle  in  NUM_ENGINES  bit i high means engine i can accept a pixel.
- queue_full  in  NUM_ENGINES  bit i high means engine i's reorder queue is full.
- start_o  out  NUM_ENGINES  one-hot, single-cycle dispatch strobe.
- xpixel_o  out  DATA_WIDTH  x coordinate, valid while any start_o bit is high.
- ypixel_o  out  DATA_WIDTH  y coordinate, valid while any start_o bit is high.
- grant_idx_o  out  ENG_IDX_WIDTH  index of the engine granted this cycle.
- busy_o  out  1  high in every state except IDLE.
- frame_done_o  out  1  single-cycle pulse at end of frame.

Behaviour:
- Reset: clk and reset as already decided (synchronous, active-high). Reset forces state IDLE and clears the internal x/y counters, the round-robin pointer (rr_ptr) and the block mask. All outputs are 0.
- Reset mid-frame: the frame is abandoned with no frame_done_o. Engines are not notified.
- States:
  - IDLE: frame_start goes to DISPATCH; x=0, y=0, rr_ptr=0.
  - DISPATCH: issues at most one pixel per cycle. After issuing the pixel (FRAME_W-1, FRAME_H-1), go to DRAIN.
  - DRAIN: wait until all engine_idle bits are 1, block mask is clear, then go to DONE.
  - DONE: assert frame_done_o for one cycle, then go to IDLE.
- frame_start is ignored in every state other than IDLE.
- Eligibility: eligible[i] = engine_idle[i] & ~queue_full[i] & ~block[i].
- Arbitration: grant the first eligible engine searching upward from rr_ptr, wrapping modulo NUM_ENGINES. On a grant, rr_ptr becomes grant+1 (wrapping).
- Dispatch outputs:
  - start_o, xpixel_o, ypixel_o and grant_idx_o are registered.
  - They are presented in the cycle after the grant decision, so decision-to-strobe latency is 1 cycle.
  - When no strobe is active, xpixel_o, ypixel_o and grant_idx_o hold their last values.
- Block mask: block[g] is set on the grant cycle and cleared 2 cycles later. This covers the strobe cycle plus the engine's 1-cycle idle deassertion.
- No eligible engine: nothing is issued and the x/y counters hold (stall).
- Coordinate counters:
  - x advances only on a grant.
  - When x = FRAME_W-1, x wraps to 0 and y increments.
  - Counters are unsigned, zero-extended onto DATA_WIDTH.
- Full boundary: an engine whose queue_full is high is skipped even if it is idle. If every engine is full, dispatch stalls indefinitely. This is legal and raises no error.
- Simultaneous events: queue_full rising in the same cycle as a grant decision to that engine blocks the grant, because the decision uses the current input values.
- NUM_ENGINES=1: the block degenerates to strict single-engine sequencing.

Optional Feature:
- Macro: PIXEL_DISTRIBUTOR_PERF_EN.
- With the macro defined:
  - Adds output stall_cycles_o, 32 bits.
  - Counts DISPATCH cycles with no grant. It saturates at all-ones.
  - It clears on reset and on frame_start accepted in IDLE, and holds its value after DONE.
- Without the macro: the port and the counter are absent, and all other behaviour is identical.

Decomposition:
- Shared package pixel_pkg holds:
  - DATA_WIDTH, FRAME_W, FRAME_H defaults.
  - State enum dist_state_t {IDLE, DISPATCH, DRAIN, DONE}.
  - Typedef coord_t = logic [DATA_WIDTH-1:0].
- pixel_pkg is shared with the reorder queue and the combinator.
- One sub-module: rr_arbiter.
  - Parameterised on NUM_ENGINES.
  - Inputs: eligible vector, rr_ptr.
  - Outputs: one-hot grant, grant index, grant_valid.
  - Purely combinational.

Test Plan:
- Basic frame: NUM_ENGINES=4, FRAME_W=4, FRAME_H=2, all engines idle, no queue full, pulse frame_start.
  - Required: 8 strobes to engines 0,1,2,3,0,1,2,3 with coords (0,0)..(3,0),(0,1)..(3,1).
  - Required: frame_done_o pulses once after all engines return idle.
- Full skip: hold queue_full[1]=1 for the whole frame.
  - Required: engine 1 never strobed; grant order 0,2,3,0,2,3,...; the raster order of issued coordinates is unchanged.
- Total stall: all queue_full=1 for 10 cycles mid-frame.
  - Required: no strobes; coordinates resume exactly at the next unissued pixel.
  - Required with PIXEL_DISTRIBUTOR_PERF_EN: stall_cycles_o is 10.
- Ignored start: frame_start pulsed during DISPATCH and again during DRAIN.
  - Required: no restart, pixel count stays 8, exactly one frame_done_o.
- Reset mid-frame: assert reset after 3 strobes.
  - Required: the next cycle has start_o=0 and busy_o=0.
  - Required: a new frame_start restarts at (0,0) with engine 0.
- Re-grant guard: NUM_ENGINES=1, engine_idle tied high.
  - Required: strobes are never closer than 3 cycles apart, because of the 2-cycle block mask.
